// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_pipe
// Description : Parametrised 3-stage pipelined floating-point multiplier with
//               valid/ready flow control, round-to-nearest-even, FTZ handling
//               of subnormals, special-case handling, status flags and a
//               sideband tag carried with each operand pair.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0]        BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // The whole pipeline advances as one unit whenever the output slot frees up.
  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // ---------------- Stage 1: unpack, classify, multiply --------------------
  logic             w_a_sign, w_b_sign, w_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [PW-1:0]    w_prod;
  logic signed [EW-1:0] w_exp_sum;
  logic             w_s1_special, w_s1_spec_inv;
  logic [W-1:0]     w_s1_spec_res;

  assign w_a_sign = a[W-1];
  assign w_b_sign = b[W-1];
  assign w_a_exp  = a[W-2:MAN_W];
  assign w_b_exp  = b[W-2:MAN_W];
  assign w_a_frac = a[MAN_W-1:0];
  assign w_b_frac = b[MAN_W-1:0];
  assign w_sign   = w_a_sign ^ w_b_sign;

  // Zero exponent covers both true zeros and subnormals (flushed to zero).
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_a_inf  = (&w_a_exp) & ~(|w_a_frac);
  assign w_b_inf  = (&w_b_exp) & ~(|w_b_frac);
  assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
  assign w_b_nan  = (&w_b_exp) & (|w_b_frac);

  assign w_prod    = PW'({1'b1, w_a_frac}) * PW'({1'b1, w_b_frac});
  assign w_exp_sum = {2'b00, w_a_exp} + {2'b00, w_b_exp} - BIAS;

  // Special operands fix the result up front; arithmetic is then ignored.
  always_comb begin
    w_s1_special  = 1'b0;
    w_s1_spec_inv = 1'b0;
    w_s1_spec_res = '0;
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
      w_s1_special  = 1'b1;
      w_s1_spec_inv = 1'b1;
      w_s1_spec_res = QNAN;
    end else if (w_a_inf | w_b_inf) begin
      w_s1_special  = 1'b1;
      w_s1_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero | w_b_zero) begin
      w_s1_special  = 1'b1;
      w_s1_spec_res = {w_sign, {(W-1){1'b0}}};
    end
  end

  logic                 r_s1_valid, r_s1_sign, r_s1_special, r_s1_spec_inv;
  logic [TAG_W-1:0]     r_s1_tag;
  logic [PW-1:0]        r_s1_prod;
  logic signed [EW-1:0] r_s1_exp;
  logic [W-1:0]         r_s1_spec_res;

  // Stage 1 register: captures the raw product and classification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_sign     <= 1'b0;
      r_s1_special  <= 1'b0;
      r_s1_spec_inv <= 1'b0;
      r_s1_tag      <= '0;
      r_s1_prod     <= '0;
      r_s1_exp      <= '0;
      r_s1_spec_res <= '0;
    end else if (w_adv) begin
      r_s1_valid    <= in_valid;
      r_s1_sign     <= w_sign;
      r_s1_special  <= w_s1_special;
      r_s1_spec_inv <= w_s1_spec_inv;
      r_s1_tag      <= in_tag;
      r_s1_prod     <= w_prod;
      r_s1_exp      <= w_exp_sum;
      r_s1_spec_res <= w_s1_spec_res;
    end
  end

  // ---------------- Stage 2: normalise, extract guard/sticky ---------------
  // Product of two [1,2) significands lies in [1,4); the top bit drops here.
  logic [PW-2:0]        w_norm;
  logic [MAN_W-1:0]     w_s2_frac;
  logic                 w_s2_guard, w_s2_sticky;
  logic signed [EW-1:0] w_s2_exp;

  assign w_norm      = r_s1_prod[PW-1] ? r_s1_prod[PW-2:0] : {r_s1_prod[PW-3:0], 1'b0};
  assign w_s2_frac   = w_norm[PW-2 -: MAN_W];
  assign w_s2_guard  = w_norm[PW-2-MAN_W];
  assign w_s2_sticky = |w_norm[PW-3-MAN_W:0];
  assign w_s2_exp    = r_s1_exp + EW'(r_s1_prod[PW-1]);

  logic                 r_s2_valid, r_s2_sign, r_s2_special, r_s2_spec_inv;
  logic                 r_s2_guard, r_s2_sticky;
  logic [TAG_W-1:0]     r_s2_tag;
  logic [MAN_W-1:0]     r_s2_frac;
  logic signed [EW-1:0] r_s2_exp;
  logic [W-1:0]         r_s2_spec_res;

  // Stage 2 register: normalised mantissa with rounding information.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid    <= 1'b0;
      r_s2_sign     <= 1'b0;
      r_s2_special  <= 1'b0;
      r_s2_spec_inv <= 1'b0;
      r_s2_guard    <= 1'b0;
      r_s2_sticky   <= 1'b0;
      r_s2_tag      <= '0;
      r_s2_frac     <= '0;
      r_s2_exp      <= '0;
      r_s2_spec_res <= '0;
    end else if (w_adv) begin
      r_s2_valid    <= r_s1_valid;
      r_s2_sign     <= r_s1_sign;
      r_s2_special  <= r_s1_special;
      r_s2_spec_inv <= r_s1_spec_inv;
      r_s2_guard    <= w_s2_guard;
      r_s2_sticky   <= w_s2_sticky;
      r_s2_tag      <= r_s1_tag;
      r_s2_frac     <= w_s2_frac;
      r_s2_exp      <= w_s2_exp;
      r_s2_spec_res <= r_s1_spec_res;
    end
  end

  // ---------------- Stage 3: round, range-check, pack ----------------------
  logic                 w_round_up, w_carry;
  logic [MAN_W-1:0]     w_frac_rnd;
  logic signed [EW-1:0] w_e3;
  logic [W-1:0]         w_res;
  logic [3:0]           w_flags;

  assign w_round_up           = r_s2_guard & (r_s2_sticky | r_s2_frac[0]);
  assign {w_carry, w_frac_rnd} = {1'b0, r_s2_frac} + {{MAN_W{1'b0}}, w_round_up};
  assign w_e3                 = r_s2_exp + EW'(w_carry);

  // Final packing; flags are {invalid, overflow, underflow, inexact}.
  always_comb begin
    w_res   = '0;
    w_flags = 4'b0000;
    if (r_s2_special) begin
      w_res   = r_s2_spec_res;
      w_flags = {r_s2_spec_inv, 3'b000};
    end else if (w_e3 >= EXP_MAX) begin
      w_res   = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags = 4'b0101;
    end else if (w_e3[EW-1] || (w_e3 == '0)) begin
      w_res   = {r_s2_sign, {(W-1){1'b0}}};
      w_flags = 4'b0011;
    end else begin
      w_res   = {r_s2_sign, w_e3[EXP_W-1:0], w_frac_rnd};
      w_flags = {3'b000, r_s2_guard | r_s2_sticky};
    end
  end

  // Output register: holds its contents while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      flags     <= 4'b0000;
    end else if (w_adv) begin
      out_valid <= r_s2_valid;
      result    <= w_res;
      out_tag   <= r_s2_tag;
      flags     <= w_flags;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mult_pipe
// Description : Self-checking bench for fp_mult_pipe (single precision).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [7:0]  out_tag;
  logic [3:0]  flags;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [7:0]  tag;
    logic [3:0]  flg;
  } exp_t;

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .flags(flags)
  );

  // Reference: exact integer product, rounded by comparing the discarded
  // remainder against half an ulp.
  task automatic ref_model(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] res, output logic [3:0] flg);
    logic s;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    logic zx, zy, ix, iy, nx, ny;
    longint unsigned p, q, r, half;
    int msb, sh, e;
    s = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    zx = (ex == 8'd0); zy = (ey == 8'd0);
    ix = (ex == 8'hFF) && (fx == 23'd0); iy = (ey == 8'hFF) && (fy == 23'd0);
    nx = (ex == 8'hFF) && (fx != 23'd0); ny = (ey == 8'hFF) && (fy != 23'd0);
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      res = 32'h7FC00000; flg = 4'b1000;
    end else if (ix || iy) begin
      res = {s, 8'hFF, 23'd0}; flg = 4'b0000;
    end else if (zx || zy) begin
      res = {s, 31'd0}; flg = 4'b0000;
    end else begin
      p = ((64'd1 << 23) | {41'd0, fx}) * ((64'd1 << 23) | {41'd0, fy});
      msb = p[47] ? 47 : 46;
      sh = msb - 23;
      q = p >> sh;
      r = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      e = int'(ex) + int'(ey) - 127 + (msb - 46);
      if (r > half || (r == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0}; flg = 4'b0101;
      end else if (e <= 0) begin
        res = {s, 31'd0}; flg = 4'b0011;
      end else begin
        res = {s, e[7:0], q[22:0]}; flg = {3'b000, (r != 64'd0)};
      end
    end
  endtask

  function automatic logic [31:0] gen_op();
    int k;
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    k = int'($urandom_range(99));
    s = 1'($urandom_range(1));
    f = 23'($urandom);
    if ($urandom_range(3) == 0) f[11:0] = 12'd0;
    if (k < 55)      e = 8'(100 + $urandom_range(54));
    else if (k < 75) e = 8'($urandom_range(254, 1));
    else if (k < 80) begin e = 8'd0; f = 23'd0; end
    else if (k < 85) e = 8'd0;
    else if (k < 90) begin e = 8'hFF; f = 23'd0; end
    else if (k < 93) begin e = 8'hFF; f = f | 23'd1; end
    else e = 8'(($urandom_range(1) != 0) ? $urandom_range(4, 1) : $urandom_range(254, 250));
    return {s, e, f};
  endfunction

  // Present one operand pair with out_ready held high; report the result and
  // the number of edges from the accepting edge until out_valid shows up.
  task automatic issue_single(input logic [31:0] xa, input logic [31:0] xb, input logic [7:0] xt,
                              output logic [31:0] r, output logic [7:0] t,
                              output logic [3:0] f, output int lat);
    @(negedge clk);
    a = xa; b = xb; in_tag = xt; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1; r = '0; t = '0; f = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i; r = result; t = out_tag; f = flags;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (out_tag !== 8'd0) begin fails++; $display("FAIL reset_out_tag: got %h expected 00", out_tag); end
    checks++; if (flags !== 4'd0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] va [13];
    logic [31:0] vb [13];
    logic [31:0] vr [13];
    logic [3:0]  vf [13];
    logic [31:0] r;
    logic [7:0]  t;
    logic [3:0]  f;
    int lat;
    va = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000,
           32'h7F800000, 32'hFF800000, 32'h00000001, 32'h7FC12345, 32'h80000000,
           32'h3F800001, 32'h00800000, 32'h7F000000};
    vb = '{32'h40400000, 32'hBFC00000, 32'h3FC00000, 32'h40000000, 32'h3F000000,
           32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'hC0A00000,
           32'h3FFFFFFE, 32'h3F800000, 32'h3F800000};
    vr = '{32'h40C00000, 32'hC0100000, 32'h3FC00002, 32'h7F800000, 32'h00000000,
           32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h00000000,
           32'h40000000, 32'h00800000, 32'h7F000000};
    vf = '{4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b0011,
           4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
           4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 13; i++) begin
      issue_single(va[i], vb[i], 8'(8'hC0 + i), r, t, f, lat);
      checks++; if (r !== vr[i]) begin fails++; $display("FAIL directed_result[%0d]: got %h expected %h", i, r, vr[i]); end
      checks++; if (f !== vf[i]) begin fails++; $display("FAIL directed_flags[%0d]: got %b expected %b", i, f, vf[i]); end
      checks++; if (t !== 8'(8'hC0 + i)) begin fails++; $display("FAIL directed_tag[%0d]: got %h expected %h", i, t, 8'(8'hC0 + i)); end
      checks++; if (lat != 3) begin fails++; $display("FAIL directed_latency[%0d]: got %0d expected 3", i, lat); end
    end
  endtask

  task automatic test_back_to_back(input int n);
    exp_t q[$];
    exp_t ex;
    logic [31:0] mr;
    logic [3:0] mf;
    int got = 0, first = -1, last = -1;
    for (int cyc = 0; cyc < n + 12; cyc++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      if (cyc < n) begin
        in_valid = 1'b1; a = gen_op(); b = gen_op(); in_tag = 8'(8'h40 + cyc);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (cyc < n) begin
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
      end
      if (in_valid && in_ready) begin
        ref_model(a, b, mr, mf);
        ex.res = mr; ex.tag = in_tag; ex.flg = mf;
        q.push_back(ex);
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b_spurious: got out_valid=1 tag=%h expected no output", out_tag);
        end else begin
          ex = q.pop_front();
          got++;
          if (first < 0) first = cyc;
          last = cyc;
          if ({result, out_tag, flags} !== {ex.res, ex.tag, ex.flg}) begin
            fails++;
            $display("FAIL b2b_output: got res=%h tag=%h flg=%b expected res=%h tag=%h flg=%b",
                     result, out_tag, flags, ex.res, ex.tag, ex.flg);
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != n || (last - first + 1) != n) begin
      fails++; $display("FAIL b2b_throughput: got %0d results over %0d cycles expected %0d over %0d", got, last - first + 1, n, n);
    end
  endtask

  task automatic test_random_stream(input int n_ops, input int ready_pct, input logic [7:0] tag_base);
    exp_t q[$];
    exp_t ex;
    int sent = 0, got = 0, cyc = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [31:0] pres = '0;
    logic [7:0] ptag = '0;
    logic [3:0] pflg = '0;
    logic [31:0] mr;
    logic [3:0] mf;
    while ((sent < n_ops || q.size() != 0) && cyc < 20 * n_ops + 100) begin
      @(posedge clk);
      #1;
      if (sent < n_ops && $urandom_range(99) < 75) begin
        in_valid = 1'b1; a = gen_op(); b = gen_op(); in_tag = tag_base + 8'(sent);
      end else in_valid = 1'b0;
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (pv && !pr) begin
        checks++;
        if (out_valid !== 1'b1 || result !== pres || out_tag !== ptag || flags !== pflg) begin
          fails++;
          $display("FAIL stall_hold: got v=%b res=%h tag=%h flg=%b expected v=1 res=%h tag=%h flg=%b",
                   out_valid, result, out_tag, flags, pres, ptag, pflg);
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        fails++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, (!out_valid || out_ready));
      end
      if (in_valid && in_ready) begin
        ref_model(a, b, mr, mf);
        ex.res = mr; ex.tag = in_tag; ex.flg = mf;
        q.push_back(ex);
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          fails++; $display("FAIL stream_spurious: got tag=%h expected no output", out_tag);
        end else begin
          ex = q.pop_front();
          got++;
          if ({result, out_tag, flags} !== {ex.res, ex.tag, ex.flg}) begin
            fails++;
            $display("FAIL stream_output: got res=%h tag=%h flg=%b expected res=%h tag=%h flg=%b",
                     result, out_tag, flags, ex.res, ex.tag, ex.flg);
          end
        end
      end
      pv = out_valid; pr = out_ready; pres = result; ptag = out_tag; pflg = flags;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != n_ops || q.size() != 0) begin
      fails++; $display("FAIL stream_count: got %0d results (%0d pending) expected %0d", got, q.size(), n_ops);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] r;
    logic [7:0] t;
    logic [3:0] f;
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; out_ready = 1'b1; a = gen_op(); b = gen_op(); in_tag = 8'(8'hA0 + i);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL inflight_pre: got out_valid=%b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL inflight_async_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'd0) begin fails++; $display("FAIL inflight_async_result: got %h expected 00000000", result); end
    checks++; if (out_tag !== 8'd0) begin fails++; $display("FAIL inflight_async_tag: got %h expected 00", out_tag); end
    checks++; if (flags !== 4'd0) begin fails++; $display("FAIL inflight_async_flags: got %b expected 0000", flags); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    issue_single(32'h40000000, 32'h40400000, 8'h5A, r, t, f, lat);
    checks++; if (lat != 3) begin fails++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
    checks++; if (r !== 32'h40C00000) begin fails++; $display("FAIL post_reset_result: got %h expected 40c00000", r); end
    checks++; if (t !== 8'h5A) begin fails++; $display("FAIL post_reset_tag: got %h expected 5a", t); end
    checks++; if (f !== 4'd0) begin fails++; $display("FAIL post_reset_flags: got %b expected 0000", f); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(12);
    test_random_stream(8, 50, 8'h10);
    test_random_stream(300, 60, 8'h00);
    test_random_stream(60, 15, 8'h80);
    test_reset_inflight();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
